// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory that sits behind the datapath's MAR/MDR interface.
// A read accepted at edge k presents its word on Mdatain, together with a
// one-cycle MemReady pulse, after edge k+READ_LATENCY. A write commits on its
// acceptance edge and pulses MemReady after the following edge. Only one
// access is in flight at a time. Requests that arrive while busy are dropped
// and flagged, and they are never queued.
//
// Ports
//   clock     in   rising-edge clock
//   clear     in   asynchronous active-low reset
//   MARaddr   in   [31:0]  address; only [ADDR_WIDTH-1:0] is used, so addresses wrap
//   Read      in   read request, sampled only in IDLE
//   Write     in   write request, sampled only in IDLE
//   MDRdata   in   [DATA_WIDTH-1:0] write data
//   Mdatain   out  [DATA_WIDTH-1:0] read data; holds until the next read completes
//   MemReady  out  one-cycle pulse when a read or a write completes
//   Busy      out  high while an access is in flight
//   ReqErr    out  one-cycle pulse: Read and Write were both high in IDLE
//   ReqDrop   out  one-cycle pulse: a request arrived while busy
//
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2      // legal range 1..7
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           MARaddr,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] MDRdata,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  MemReady,
    output logic                  Busy,
    output logic                  ReqErr,
    output logic                  ReqDrop
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_DONE = 2'd2,
        S_WR_DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   mdatain_q, mdatain_d;
    logic                    memready_q, memready_d;
    logic                    busy_q, busy_d;
    logic                    reqerr_q, reqerr_d;
    logic                    reqdrop_q, reqdrop_d;
    logic                    mem_we_s;
    logic                    req_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    unused_addr_s;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign addr_s        = MARaddr[ADDR_WIDTH-1:0];
    assign req_s         = Read | Write;
    // The upper MAR bits are deliberately ignored so addresses alias.
    assign unused_addr_s = ^MARaddr[31:ADDR_WIDTH];

    // Next-state, datapath and pulse-output logic for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        mdatain_d  = mdatain_q;
        memready_d = 1'b0;
        reqerr_d   = 1'b0;
        reqdrop_d  = 1'b0;
        mem_we_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Read && Write) begin
                    reqerr_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (Read) begin
                    addr_d = addr_s;
                    cnt_d  = CNT_LOAD;
                    if (READ_LATENCY == 1) begin
                        state_d = S_RD_DONE;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end else if (Write) begin
                    // The write lands on the acceptance edge, so a read that
                    // follows it sees the new word.
                    mem_we_s = 1'b1;
                    state_d  = S_WR_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                reqdrop_d = req_s;
                cnt_d     = cnt_q - 3'd1;
                // Leave on the edge where the counter reaches zero. RD_DONE then
                // lasts one cycle and its exit edge raises MemReady, which
                // places the data READ_LATENCY edges after acceptance.
                if (cnt_q == 3'd1) begin
                    state_d = S_RD_DONE;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_DONE: begin
                reqdrop_d  = req_s;
                mdatain_d  = mem_q[addr_q];
                memready_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_WR_DONE: begin
                reqdrop_d  = req_s;
                memready_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            mdatain_q  <= '0;
            memready_q <= 1'b0;
            busy_q     <= 1'b0;
            reqerr_q   <= 1'b0;
            reqdrop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            mdatain_q  <= mdatain_d;
            memready_q <= memready_d;
            busy_q     <= busy_d;
            reqerr_q   <= reqerr_d;
            reqdrop_q  <= reqdrop_d;
        end
    end

    // Storage array. It is not reset. A write strobe seen while clear is low
    // is ignored, so writes cannot happen while the block is held in reset.
    always_ff @(posedge clock) begin
        if (mem_we_s && clear) begin
            mem_q[addr_s] <= MDRdata;
        end
    end

    assign Mdatain  = mdatain_q;
    assign MemReady = memready_q;
    assign Busy     = busy_q;
    assign ReqErr   = reqerr_q;
    assign ReqDrop  = reqdrop_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Drives three mem_responder instances with READ_LATENCY = 1, 2 and 4 from the
// same stimulus. A transaction-level model, kept per instance, tracks:
//   - the memory contents
//   - which access is in flight and the edge on which it completes
//   - the expected outputs after every edge
// A compare process checks every output of every instance on each falling
// edge. Directed sequences add literal expectations taken from the
// specification's worked cases.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clock;
    logic        clear;
    logic [31:0] MARaddr;
    logic        Read;
    logic        Write;
    logic [31:0] MDRdata;

    logic [2:0][31:0] md_w;
    logic [2:0]       rdy_w;
    logic [2:0]       busy_w;
    logic [2:0]       err_w;
    logic [2:0]       drop_w;

    int n_chk;
    int n_fail;

    int lat [3];
    initial begin
        lat[0] = 1;
        lat[1] = 2;
        lat[2] = 4;
    end

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(1)) u_l1 (
        .clock(clock), .clear(clear), .MARaddr(MARaddr), .Read(Read), .Write(Write),
        .MDRdata(MDRdata), .Mdatain(md_w[0]), .MemReady(rdy_w[0]), .Busy(busy_w[0]),
        .ReqErr(err_w[0]), .ReqDrop(drop_w[0]));

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2)) u_l2 (
        .clock(clock), .clear(clear), .MARaddr(MARaddr), .Read(Read), .Write(Write),
        .MDRdata(MDRdata), .Mdatain(md_w[1]), .MemReady(rdy_w[1]), .Busy(busy_w[1]),
        .ReqErr(err_w[1]), .ReqDrop(drop_w[1]));

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(4)) u_l4 (
        .clock(clock), .clear(clear), .MARaddr(MARaddr), .Read(Read), .Write(Write),
        .MDRdata(MDRdata), .Mdatain(md_w[2]), .MemReady(rdy_w[2]), .Busy(busy_w[2]),
        .ReqErr(err_w[2]), .ReqDrop(drop_w[2]));

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem  [3][512];
    bit          m_pend [3];
    bit          m_isrd [3];
    logic [31:0] m_rval [3];
    int          m_done [3];
    int          m_t;
    logic [31:0] e_md   [3];
    bit          e_rdy  [3];
    bit          e_busy [3];
    bit          e_err  [3];
    bit          e_drop [3];

    initial m_t = 0;

    // Step the model at every edge, or reset it as soon as clear falls.
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 1'b0;
                e_md[i]   = 32'd0;
                e_rdy[i]  = 1'b0;
                e_busy[i] = 1'b0;
                e_err[i]  = 1'b0;
                e_drop[i] = 1'b0;
            end
        end else begin
            m_t = m_t + 1;
            for (int i = 0; i < 3; i++) begin
                e_rdy[i]  = 1'b0;
                e_err[i]  = 1'b0;
                e_drop[i] = 1'b0;
                if (Read || Write) begin
                    if (m_pend[i]) begin
                        e_drop[i] = 1'b1;
                    end else if (Read && Write) begin
                        e_err[i] = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                        m_isrd[i] = Read;
                        if (Read) begin
                            m_rval[i] = m_mem[i][MARaddr % 512];
                            m_done[i] = m_t + lat[i];
                        end else begin
                            m_mem[i][MARaddr % 512] = MDRdata;
                            m_done[i] = m_t + 1;
                        end
                    end
                end
                if (m_pend[i] && (m_done[i] == m_t)) begin
                    e_rdy[i] = 1'b1;
                    if (m_isrd[i]) begin
                        e_md[i] = m_rval[i];
                    end
                    m_pend[i] = 1'b0;
                end
                e_busy[i] = m_pend[i];
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("Mdatain[L%0d]", lat[i]),  md_w[i],            e_md[i]);
            check($sformatf("MemReady[L%0d]", lat[i]), {31'd0, rdy_w[i]},  {31'd0, e_rdy[i]});
            check($sformatf("Busy[L%0d]", lat[i]),     {31'd0, busy_w[i]}, {31'd0, e_busy[i]});
            check($sformatf("ReqErr[L%0d]", lat[i]),   {31'd0, err_w[i]},  {31'd0, e_err[i]});
            check($sformatf("ReqDrop[L%0d]", lat[i]),  {31'd0, drop_w[i]}, {31'd0, e_drop[i]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        Read    = r;
        Write   = w;
        MARaddr = a;
        MDRdata = d;
        @(negedge clock);
        Read  = 1'b0;
        Write = 1'b0;
    endtask

    // Issue one read, then check that MemReady arrives exactly lat edges later
    // with the expected word, and that the word is still held afterwards.
    task automatic read_sweep(input logic [31:0] a, input logic [31:0] exp);
        req(1'b1, 1'b0, a, 32'd0);
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("lit_rdy_L%0d_j%0d", lat[i], j),
                      {31'd0, rdy_w[i]}, (lat[i] == j) ? 32'd1 : 32'd0);
                if (lat[i] <= j) begin
                    check($sformatf("lit_data_L%0d_j%0d", lat[i], j), md_w[i], exp);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic all_zero(input string nm);
        check({nm, "_rdy"},  {29'd0, rdy_w},  32'd0);
        check({nm, "_busy"}, {29'd0, busy_w}, 32'd0);
        check({nm, "_err"},  {29'd0, err_w},  32'd0);
        check({nm, "_drop"}, {29'd0, drop_w}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_md_L%0d", nm, lat[i]), md_w[i], 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int x;
        n_chk   = 0;
        n_fail  = 0;
        clear   = 1'b1;
        Read    = 1'b0;
        Write   = 1'b0;
        MARaddr = 32'd0;
        MDRdata = 32'd0;
        #1 clear = 1'b0;
        #1 all_zero("reset");
        @(negedge clock);
        #2 clear = 1'b1;
        @(negedge clock);
        check("busy_after_release", {29'd0, busy_w}, 32'd0);

        // Fill the whole array with back-to-back writes so every later read is defined.
        for (int a = 0; a < 512; a++) begin
            req(1'b0, 1'b1, a, $urandom);
        end
        @(negedge clock);

        // Random traffic: reads, writes, illegal pairs, and drops while busy.
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            x       = int'($urandom_range(0, 9));
            Read    = (x < 3) || (x == 6);
            Write   = ((x >= 3) && (x < 6)) || (x == 6);
            MARaddr = $urandom;
            MDRdata = $urandom;
        end
        @(negedge clock);
        Read  = 1'b0;
        Write = 1'b0;
        repeat (8) @(negedge clock);

        // Write then read, with the latency swept across the three instances.
        req(1'b0, 1'b1, 32'h0000_0010, 32'h8A2B_8000);
        check("wr_busy_k", {29'd0, busy_w}, 32'd7);
        check("wr_rdy_k",  {29'd0, rdy_w},  32'd0);
        @(negedge clock);
        check("wr_rdy_k1", {29'd0, rdy_w},  32'd7);
        read_sweep(32'h0000_0010, 32'h8A2B_8000);

        // Address aliasing.
        req(1'b0, 1'b1, 32'h0000_0205, 32'h0000_0022);
        @(negedge clock);
        read_sweep(32'h0000_0005, 32'h0000_0022);

        // Illegal request: no access, and the array is left unchanged.
        req(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("err_pulse", {29'd0, err_w}, 32'd7);
        check("err_nordy", {29'd0, rdy_w}, 32'd0);
        @(negedge clock);
        check("err_one_cycle", {29'd0, err_w}, 32'd0);
        read_sweep(32'h0000_0010, 32'h8A2B_8000);

        // Drop: a second read while busy is ignored and the first read completes.
        @(negedge clock);
        Read    = 1'b1;
        MARaddr = 32'h0000_0010;
        @(negedge clock);
        MARaddr = 32'h0000_0005;
        @(negedge clock);
        Read = 1'b0;
        check("drop_pulse", {29'd0, drop_w}, 32'd7);
        for (int j = 1; j < 6; j++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("drop_rdy_L%0d_j%0d", lat[i], j),
                      {31'd0, rdy_w[i]}, (lat[i] == j) ? 32'd1 : 32'd0);
                if (lat[i] <= j) begin
                    check($sformatf("drop_data_L%0d", lat[i]), md_w[i], 32'h8A2B_8000);
                end
            end
            @(negedge clock);
        end

        // Reset during a read: the read is abandoned and the next read works.
        req(1'b1, 1'b0, 32'h0000_0005, 32'd0);
        #2 clear = 1'b0;
        #1 all_zero("midreset");
        @(negedge clock);
        @(negedge clock);
        #2 clear = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            check("midreset_nordy", {29'd0, rdy_w}, 32'd0);
            check("midreset_md0",   md_w[1],        32'd0);
        end
        read_sweep(32'h0000_0005, 32'h0000_0022);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
